// File: rtl/dm_axi_master.sv
// Bridges a CPU data-memory port onto single-beat AXI4 read/write channels.
// At most one transaction is outstanding; the CPU is held by AXI_MEM_stall until it completes.
module dm_axi_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        DM_read,
    input  logic [3:0]  DM_write_en,
    input  logic [31:0] DM_addr,
    input  logic [31:0] DM_data_write,
    output logic [31:0] DM_data_read,
    output logic        AXI_MEM_stall,
    output logic [31:0] ARADDR,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RVALID,
    output logic        RREADY,
    output logic [31:0] AWADDR,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic store_req, req, aw_hs, w_hs, rd_done, wr_done;

    // Error responses are not reported to the CPU; transactions complete normally.
    logic unused_resp;
    assign unused_resp = ^{RRESP, BRESP};

    assign store_req = |DM_write_en;
    assign req       = DM_read | store_req;
    assign aw_hs     = AWVALID & AWREADY;
    assign w_hs      = WVALID & WREADY;
    assign rd_done   = (state_q == RD_DATA) & RVALID;
    assign wr_done   = (state_q == WR_RESP) & BVALID;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = DM_addr;
                    wdata_d = DM_data_write;
                    wstrb_d = DM_write_en;
                    state_d = store_req ? WR_ADDR : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (ARREADY) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (RVALID) begin
                    rdata_d = RDATA;
                    state_d = IDLE;
                end
            end
            WR_ADDR: begin
                // The two channels may be accepted in either order or together.
                if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end else begin
                    aw_done_d = aw_done_q | aw_hs;
                    w_done_d  = w_done_q | w_hs;
                end
            end
            WR_RESP: begin
                if (BVALID) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ARADDR  = addr_q;
    assign ARVALID = (state_q == RD_ADDR);
    assign RREADY  = (state_q == RD_DATA);
    assign AWADDR  = addr_q;
    assign AWVALID = (state_q == WR_ADDR) & ~aw_done_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WVALID  = (state_q == WR_ADDR) & ~w_done_q;
    assign BREADY  = (state_q == WR_RESP);

    // Stall releases in the completing handshake cycle so the CPU can advance immediately.
    assign AXI_MEM_stall = rst & (((state_q == IDLE) & req) |
                                  ((state_q != IDLE) & ~rd_done & ~wr_done));
    assign DM_data_read  = rd_done ? RDATA : rdata_q;

endmodule

// File: tb/tb_dm_axi_master.sv
// Directed bench for dm_axi_master: each task drives one scenario cycle by cycle
// and compares outputs against hand-derived values.
module tb_dm_axi_master;

    logic        clk;
    logic        rst;
    logic        DM_read;
    logic [3:0]  DM_write_en;
    logic [31:0] DM_addr;
    logic [31:0] DM_data_write;
    logic [31:0] DM_data_read;
    logic        AXI_MEM_stall;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;

    int checks;
    int errors;
    int ar_count;

    dm_axi_master dut (
        .clk           (clk),
        .rst           (rst),
        .DM_read       (DM_read),
        .DM_write_en   (DM_write_en),
        .DM_addr       (DM_addr),
        .DM_data_write (DM_data_write),
        .DM_data_read  (DM_data_read),
        .AXI_MEM_stall (AXI_MEM_stall),
        .ARADDR        (ARADDR),
        .ARVALID       (ARVALID),
        .ARREADY       (ARREADY),
        .RDATA         (RDATA),
        .RRESP         (RRESP),
        .RVALID        (RVALID),
        .RREADY        (RREADY),
        .AWADDR        (AWADDR),
        .AWVALID       (AWVALID),
        .AWREADY       (AWREADY),
        .WDATA         (WDATA),
        .WSTRB         (WSTRB),
        .WVALID        (WVALID),
        .WREADY        (WREADY),
        .BRESP         (BRESP),
        .BVALID        (BVALID),
        .BREADY        (BREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts AR handshakes to detect duplicate reads.
    always @(posedge clk) begin
        if (ARVALID && ARREADY) ar_count <= ar_count + 1;
    end

    task automatic clear_inputs();
        DM_read = 1'b0; DM_write_en = 4'h0; DM_addr = '0; DM_data_write = '0;
        ARREADY = 1'b0; RDATA = '0; RRESP = 2'b00; RVALID = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BRESP = 2'b00; BVALID = 1'b0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        DM_read = 1'b1;
        next_cycle(); #1;
        checks++; if (AXI_MEM_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", AXI_MEM_stall); end
        checks++; if ({ARVALID, RREADY, AWVALID, WVALID, BREADY} !== 5'b0) begin errors++; $display("FAIL reset_handshakes: got %b want 00000", {ARVALID, RREADY, AWVALID, WVALID, BREADY}); end
        checks++; if (DM_data_read !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 00000000", DM_data_read); end
        checks++; if ({ARADDR, WDATA, WSTRB} !== 68'h0) begin errors++; $display("FAIL reset_captured: got %h want 0", {ARADDR, WDATA, WSTRB}); end
        DM_read = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        $display("reset: outputs cleared while rst low");
    endtask

    task automatic test_load();
        clear_inputs();
        ARREADY = 1'b1;
        DM_read = 1'b1; DM_addr = 32'h1000_0008;
        #1;
        checks++; if (AXI_MEM_stall !== 1'b1) begin errors++; $display("FAIL load_c0_stall: got %b want 1", AXI_MEM_stall); end
        checks++; if (ARVALID !== 1'b0) begin errors++; $display("FAIL load_c0_arvalid: got %b want 0", ARVALID); end
        next_cycle(); #1;
        checks++; if (ARVALID !== 1'b1) begin errors++; $display("FAIL load_c1_arvalid: got %b want 1", ARVALID); end
        checks++; if (ARADDR !== 32'h1000_0008) begin errors++; $display("FAIL load_c1_araddr: got %h want 10000008", ARADDR); end
        checks++; if (AXI_MEM_stall !== 1'b1) begin errors++; $display("FAIL load_c1_stall: got %b want 1", AXI_MEM_stall); end
        next_cycle();
        RVALID = 1'b1; RDATA = 32'hDEAD_BEEF;
        #1;
        checks++; if (RREADY !== 1'b1) begin errors++; $display("FAIL load_c2_rready: got %b want 1", RREADY); end
        checks++; if (AXI_MEM_stall !== 1'b0) begin errors++; $display("FAIL load_c2_stall: got %b want 0", AXI_MEM_stall); end
        checks++; if (DM_data_read !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_c2_data: got %h want deadbeef", DM_data_read); end
        next_cycle();
        DM_read = 1'b0; RVALID = 1'b0; RDATA = 32'h0;
        #1;
        checks++; if (DM_data_read !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_c3_held: got %h want deadbeef", DM_data_read); end
        checks++; if ({AXI_MEM_stall, RREADY, ARVALID} !== 3'b000) begin errors++; $display("FAIL load_c3_idle: got %b want 000", {AXI_MEM_stall, RREADY, ARVALID}); end
        next_cycle();
        $display("load: addr 10000008 data deadbeef");
    endtask

    task automatic test_store_delayed();
        clear_inputs();
        WREADY = 1'b1;
        DM_write_en = 4'b0011; DM_addr = 32'h0001_0004; DM_data_write = 32'h1122_3344;
        #1;
        checks++; if (AXI_MEM_stall !== 1'b1) begin errors++; $display("FAIL store_c0_stall: got %b want 1", AXI_MEM_stall); end
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            if (c == 2) begin DM_addr = 32'hFFFF_FFFF; DM_data_write = 32'h0; DM_write_en = 4'hC; end
            AWREADY = (c == 4);
            #1;
            checks++; if (AWVALID !== 1'b1) begin errors++; $display("FAIL store_c%0d_awvalid: got %b want 1", c, AWVALID); end
            checks++; if (WVALID !== (c == 1)) begin errors++; $display("FAIL store_c%0d_wvalid: got %b want %b", c, WVALID, (c == 1)); end
            checks++; if (AWADDR !== 32'h0001_0004) begin errors++; $display("FAIL store_c%0d_awaddr: got %h want 00010004", c, AWADDR); end
            checks++; if (AXI_MEM_stall !== 1'b1) begin errors++; $display("FAIL store_c%0d_stall: got %b want 1", c, AXI_MEM_stall); end
            if (c == 1) begin
                checks++; if ({WDATA, WSTRB} !== {32'h1122_3344, 4'b0011}) begin errors++; $display("FAIL store_wdata_wstrb: got %h/%b want 11223344/0011", WDATA, WSTRB); end
            end
        end
        next_cycle();
        AWREADY = 1'b0;
        #1;
        checks++; if ({BREADY, AWVALID, WVALID, AXI_MEM_stall} !== 4'b1001) begin errors++; $display("FAIL store_c5_resp: got %b want 1001", {BREADY, AWVALID, WVALID, AXI_MEM_stall}); end
        next_cycle();
        BVALID = 1'b1;
        #1;
        checks++; if (AXI_MEM_stall !== 1'b0) begin errors++; $display("FAIL store_c6_stall: got %b want 0", AXI_MEM_stall); end
        next_cycle();
        clear_inputs();
        #1;
        checks++; if ({BREADY, AXI_MEM_stall} !== 2'b00) begin errors++; $display("FAIL store_c7_idle: got %b want 00", {BREADY, AXI_MEM_stall}); end
        next_cycle();
        $display("store: addr 00010004 strb 0011 aw delayed 3 cycles");
    endtask

    task automatic test_priority();
        clear_inputs();
        ar_count = 0;
        ARREADY = 1'b1; AWREADY = 1'b1; WREADY = 1'b1;
        DM_read = 1'b1; DM_write_en = 4'hF; DM_addr = 32'h0000_2000; DM_data_write = 32'hCAFE_F00D;
        next_cycle(); #1;
        checks++; if ({AWVALID, WVALID, ARVALID} !== 3'b110) begin errors++; $display("FAIL prio_valids: got %b want 110", {AWVALID, WVALID, ARVALID}); end
        next_cycle();
        BVALID = 1'b1;
        #1;
        checks++; if ({ARVALID, BREADY, AXI_MEM_stall} !== 3'b010) begin errors++; $display("FAIL prio_resp: got %b want 010", {ARVALID, BREADY, AXI_MEM_stall}); end
        next_cycle();
        clear_inputs();
        next_cycle();
        checks++; if (ar_count !== 0) begin errors++; $display("FAIL prio_no_read: got %0d want 0", ar_count); end
        $display("priority: store wins over simultaneous load");
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        ar_count = 0;
        ARREADY = 1'b1; AWREADY = 1'b1; WREADY = 1'b1;
        DM_read = 1'b1; DM_addr = 32'h0000_3000;
        next_cycle();
        next_cycle();
        RVALID = 1'b1; RDATA = 32'hA5A5_5A5A;
        #1;
        checks++; if (AXI_MEM_stall !== 1'b0) begin errors++; $display("FAIL b2b_load_stall: got %b want 0", AXI_MEM_stall); end
        next_cycle();
        RVALID = 1'b0; DM_read = 1'b0;
        DM_write_en = 4'hF; DM_addr = 32'h0000_3004; DM_data_write = 32'h0BAD_F00D;
        #1;
        checks++; if ({ARVALID, AWVALID, AXI_MEM_stall} !== 3'b001) begin errors++; $display("FAIL b2b_c3: got %b want 001", {ARVALID, AWVALID, AXI_MEM_stall}); end
        next_cycle(); #1;
        checks++; if ({AWVALID, WVALID, ARVALID} !== 3'b110) begin errors++; $display("FAIL b2b_c4_valids: got %b want 110", {AWVALID, WVALID, ARVALID}); end
        checks++; if (AWADDR !== 32'h0000_3004) begin errors++; $display("FAIL b2b_awaddr: got %h want 00003004", AWADDR); end
        next_cycle();
        BVALID = 1'b1;
        #1;
        checks++; if (AXI_MEM_stall !== 1'b0) begin errors++; $display("FAIL b2b_store_stall: got %b want 0", AXI_MEM_stall); end
        next_cycle();
        clear_inputs();
        #1;
        checks++; if ({ARVALID, AWVALID, WVALID, AXI_MEM_stall} !== 4'b0000) begin errors++; $display("FAIL b2b_idle: got %b want 0000", {ARVALID, AWVALID, WVALID, AXI_MEM_stall}); end
        checks++; if (ar_count !== 1) begin errors++; $display("FAIL b2b_ar_count: got %0d want 1", ar_count); end
        next_cycle();
        $display("back_to_back: load then store, one AR");
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        ARREADY = 1'b1;
        DM_read = 1'b1; DM_addr = 32'h0000_4000;
        next_cycle();
        next_cycle(); #1;
        checks++; if ({RREADY, AXI_MEM_stall} !== 2'b11) begin errors++; $display("FAIL rstmid_rd_data: got %b want 11", {RREADY, AXI_MEM_stall}); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({RREADY, AXI_MEM_stall} !== 2'b00) begin errors++; $display("FAIL rstmid_async: got %b want 00", {RREADY, AXI_MEM_stall}); end
        checks++; if (DM_data_read !== 32'h0) begin errors++; $display("FAIL rstmid_rdata: got %h want 00000000", DM_data_read); end
        next_cycle();
        rst = 1'b1;
        DM_addr = 32'h0000_4010;
        #1;
        checks++; if (AXI_MEM_stall !== 1'b1) begin errors++; $display("FAIL rstmid_new_req: got %b want 1", AXI_MEM_stall); end
        next_cycle(); #1;
        checks++; if ({ARVALID, ARADDR} !== {1'b1, 32'h0000_4010}) begin errors++; $display("FAIL rstmid_ar: got %b/%h want 1/00004010", ARVALID, ARADDR); end
        next_cycle();
        RVALID = 1'b1; RDATA = 32'h1234_5678; RRESP = 2'b10;
        #1;
        checks++; if ({AXI_MEM_stall, DM_data_read} !== {1'b0, 32'h1234_5678}) begin errors++; $display("FAIL rstmid_reload: got %b/%h want 0/12345678", AXI_MEM_stall, DM_data_read); end
        next_cycle();
        clear_inputs();
        next_cycle();
        $display("reset_mid: abort in RD_DATA, reload 12345678");
    endtask

    task automatic test_bresp_err();
        clear_inputs();
        AWREADY = 1'b1; WREADY = 1'b1;
        DM_write_en = 4'b1000; DM_addr = 32'h0000_5003; DM_data_write = 32'hEE00_0000;
        next_cycle(); #1;
        checks++; if ({WSTRB, WDATA} !== {4'b1000, 32'hEE00_0000}) begin errors++; $display("FAIL berr_w: got %b/%h want 1000/ee000000", WSTRB, WDATA); end
        next_cycle();
        BVALID = 1'b1; BRESP = 2'b10;
        #1;
        checks++; if ({BREADY, AXI_MEM_stall} !== 2'b10) begin errors++; $display("FAIL berr_complete: got %b want 10", {BREADY, AXI_MEM_stall}); end
        next_cycle();
        clear_inputs();
        #1;
        checks++; if ({BREADY, AWVALID, AXI_MEM_stall} !== 3'b000) begin errors++; $display("FAIL berr_idle: got %b want 000", {BREADY, AWVALID, AXI_MEM_stall}); end
        next_cycle();
        $display("bresp_err: SLVERR store completed");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ar_count = 0;
        test_reset();
        test_load();
        test_store_delayed();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        test_bresp_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_axi_master.md
DM_AXI_MASTER -- requirements
Module: dm_axi_master

Interface
REQ-001 SHALL provide clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL provide rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL provide DM_read, input, 1, CPU data-load request.
REQ-004 SHALL provide DM_write_en, input, 4, CPU byte-write enables; any bit set is a store request.
REQ-005 SHALL provide DM_addr, input, 32, CPU data address.
REQ-006 SHALL provide DM_data_write, input, 32, CPU store data.
REQ-007 SHALL provide DM_data_read, output, 32, load data returned to CPU.
REQ-008 SHALL provide AXI_MEM_stall, output, 1, high while a CPU data request is unfinished.
REQ-009 SHALL provide ARADDR out 32, ARVALID out 1, ARREADY in 1, AXI read-address channel.
REQ-010 SHALL provide RDATA in 32, RRESP in 2, RVALID in 1, RREADY out 1, AXI read-data channel.
REQ-011 SHALL provide AWADDR out 32, AWVALID out 1, AWREADY in 1, AXI write-address channel.
REQ-012 SHALL provide WDATA out 32, WSTRB out 4, WVALID out 1, WREADY in 1, AXI write-data channel.
REQ-013 SHALL provide BRESP in 2, BVALID in 1, BREADY out 1, AXI write-response channel; LEN/SIZE/BURST/ID are tied by the interconnect (single-beat, 4-byte).

Function
REQ-014 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP; one outstanding transaction maximum.
REQ-015 IDLE: request = DM_read | (|DM_write_en); store SHALL take priority when both present; on request, capture DM_addr/DM_data_write/DM_write_en and go to WR_ADDR (store) or RD_ADDR (load).
REQ-016 RD_ADDR: ARVALID=1, ARADDR=captured address; on ARVALID&ARREADY go to RD_DATA; ARVALID and ARADDR SHALL stay stable until accepted.
REQ-017 RD_DATA: RREADY=1; on RVALID go to IDLE, register RDATA into the load-data register.
REQ-018 WR_ADDR: AWVALID and WVALID driven together; per-channel done flags; each VALID drops after its handshake; go to WR_RESP once both handshakes are complete (same or different cycles).
REQ-019 WR_RESP: BREADY=1; on BVALID go to IDLE.
REQ-020 AXI_MEM_stall SHALL be combinational: high when (IDLE and request) or state != IDLE, except low in the cycle of the R or B handshake that completes the transaction.
REQ-021 DM_data_read SHALL equal RDATA during the completing R handshake cycle, else the load-data register.
REQ-022 Minimum load/store latency: request in cycle 0 -> VALID high in cycle 1 -> stall low at earliest in cycle 2 (zero-wait slave).
REQ-023 RRESP/BRESP non-OKAY SHALL complete the transaction normally; read data passed through unchanged.
REQ-024 A request present in IDLE the cycle after completion SHALL be treated as a new transaction (back-to-back allowed, no idle gap required).
REQ-025 WSTRB SHALL equal captured DM_write_en; WDATA and AWADDR equal captured values, unaligned data not shifted.
REQ-026 Inputs DM_* SHALL be ignored outside IDLE.

Reset
REQ-027 While rst=0, SHALL force IDLE; all VALID/READY outputs, AXI_MEM_stall, DM_data_read, captured registers and done flags = 0.
REQ-028 Reset asserted mid-transaction SHALL abort immediately (async) without completing handshakes; after release, block SHALL accept new requests from IDLE.

Verification
REQ-029 Load, ARREADY=1, RVALID one cycle after AR, RDATA=0xDEADBEEF -> ARADDR=DM_addr, stall high cycles 0-1, low cycle 2, DM_data_read=0xDEADBEEF.
REQ-030 Store DM_write_en=4'b0011, addr 0x0001_0004, AWREADY delayed 3 cycles, WREADY=1 -> WVALID drops after 1 cycle, AWVALID held stable 4 cycles, stall drops on BVALID.
REQ-031 DM_read=1 and DM_write_en=4'hF simultaneously -> only AW/W issued, no ARVALID.
REQ-032 Back-to-back load then store with zero-wait slave -> second VALID in cycle after first completion; no duplicate transaction.
REQ-033 rst low while in RD_DATA -> RREADY, stall, DM_data_read = 0 immediately; next load after release completes normally.
REQ-034 BRESP=2'b10 on store -> completes, stall drops, FSM returns to IDLE.
